pack_uart_tx: RTL and testbench

//  Downstream of the packet assembler. Buffers the assembled byte stream (pk_data/pk_vld, frame pulse pk_frm)
//  in an on-chip FIFO and serialises it on a UART line (8N1, LSB first) to the host or master FPGA.

---
 rtl/pack_uart_pkg.sv | 23 ++
 rtl/pack_uart_ram.sv | 39 +++
 rtl/pack_uart_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_pack_uart_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_uart_pkg.sv
// pack_uart_pkg: shared definitions for the packet UART transmitter.
//   - tx_state_e : transmit FSM states (IDLE, LOAD, START, DATA, STOP)
//   - UartDbits  : data bits per UART character (8N1)
//   - DivMinDefault : default lower clamp for the baud divider
//   - clamp_div  : returns max(div, div_min)
package pack_uart_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StData  = 3'd3,
        StStop  = 3'd4
    } tx_state_e;

    localparam int unsigned UartDbits     = 8;
    localparam int unsigned DivMinDefault = 2;

    function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] div_min);
        return (div < div_min) ? div_min : div;
    endfunction

endpackage

// File: rtl/pack_uart_ram.sv
// pack_uart_ram: simple dual-port 8 x 2**AW synchronous RAM, registered read (1-cycle latency).
// Ports:
//   clk_sys  in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read byte
module pack_uart_ram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk_sys,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam int unsigned Depth = 2 ** AW;

    logic [7:0] mem_q [Depth];
    logic [7:0] rd_data_q;

    // Storage only, no reset: contents are undefined until written.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pack_uart_tx.sv
// pack_uart_tx: buffers the packet byte stream in a 2**AW-byte FIFO and serialises it as 8N1 UART,
// LSB first. When the FIFO overflows, the remainder of the current frame is dropped.
// Optional feature macro: PACK_UART_STAT_EN adds frm_cnt / drop_cnt saturating statistics outputs.
// Ports:
//   clk_sys      in   system clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   pk_data      in   packet byte
//   pk_vld       in   pk_data valid
//   pk_frm       in   start-of-packet pulse; clears drop mode
//   cfg_baud_div in   clk_sys cycles per UART bit (clamped to DIV_MIN)
//   cfg_tx_en    in   allow new bytes to start
//   uart_tx      out  serial line, idle high
//   tx_busy      out  high from START through STOP
//   fifo_lvl     out  bytes held in FIFO
//   ovf_flag     out  sticky overflow indicator
//   frm_cnt      out  pk_frm pulses seen (PACK_UART_STAT_EN only)
//   drop_cnt     out  bytes dropped (PACK_UART_STAT_EN only)
module pack_uart_tx
    import pack_uart_pkg::*;
#(
    parameter int unsigned AW      = 11,
    parameter int unsigned DIV_MIN = DivMinDefault
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [7:0]    pk_data,
    input  logic          pk_vld,
    input  logic          pk_frm,
    input  logic [15:0]   cfg_baud_div,
    input  logic          cfg_tx_en,
    output logic          uart_tx,
    output logic          tx_busy,
    output logic [AW:0]   fifo_lvl,
    output logic          ovf_flag
`ifdef PACK_UART_STAT_EN
    ,
    output logic [15:0]   frm_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam logic [15:0] DivMin  = 16'(DIV_MIN);
    localparam logic [2:0]  LastBit = 3'(UartDbits - 1);

    tx_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef PACK_UART_STAT_EN
    logic [15:0]   frm_cnt_q, frm_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

    logic       full, empty, can_pop, bit_end;
    logic       drop_eff, wr_en, drop_byte, pop;
    logic [7:0] rd_data;

    // Level never exceeds 2**AW, so the MSB alone marks a full FIFO.
    assign full    = lvl_q[AW];
    assign empty   = (lvl_q == '0);
    assign can_pop = ~empty & cfg_tx_en;
    assign bit_end = (cnt_q == (div_q - 16'd1));

    // pk_frm clears drop mode before the same-cycle byte is judged.
    assign drop_eff  = drop_q & ~pk_frm;
    assign wr_en     = pk_vld & ~full & ~drop_eff;
    assign drop_byte = pk_vld & ~wr_en;

    pack_uart_ram #(
        .AW (AW)
    ) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (pk_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // FIFO bookkeeping and overflow handling.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        drop_d   = drop_eff | (pk_vld & full);
        ovf_d    = ovf_q | drop_byte;
        lvl_d    = lvl_q;
        if (wr_en && !pop) begin
            lvl_d = lvl_q + 1'b1;
        end else if (!wr_en && pop) begin
            lvl_d = lvl_q - 1'b1;
        end
    end

    // Transmit FSM; uart_tx and tx_busy are registered with the state.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Divider is captured here so mid-byte changes wait for the next byte.
                shift_d = rd_data;
                div_d   = clamp_div(cfg_baud_div, DivMin);
                cnt_d   = '0;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                state_d = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == LastBit) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    // Back-to-back: pop during the final STOP cycle.
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef PACK_UART_STAT_EN
    always_comb begin
        frm_cnt_d  = frm_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pk_frm && (frm_cnt_q != 16'hFFFF)) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
        end
        if (drop_byte && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lvl_q      <= '0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            div_q      <= DivMin;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef PACK_UART_STAT_EN
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef PACK_UART_STAT_EN
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign uart_tx  = tx_q;
    assign tx_busy  = busy_q;
    assign fifo_lvl = lvl_q;
    assign ovf_flag = ovf_q;
`ifdef PACK_UART_STAT_EN
    assign frm_cnt  = frm_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pack_uart_tx.sv
// tb_pack_uart_tx: directed bench for pack_uart_tx (AW=4). A byte-level model tracks which bytes
// the FIFO must accept and what each serial frame must look like; one negedge process checks the
// line and busy flag every cycle against that model.
module tb_pack_uart_tx;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  pk_data = '0;
    logic        pk_vld  = 1'b0;
    logic        pk_frm  = 1'b0;
    logic [15:0] cfg_baud_div = 16'd4;
    logic        cfg_tx_en    = 1'b1;
    logic        uart_tx;
    logic        tx_busy;
    logic [AW:0] fifo_lvl;
    logic        ovf_flag;
`ifdef PACK_UART_STAT_EN
    logic [15:0] frm_cnt;
    logic [15:0] drop_cnt;
`endif

    pack_uart_tx #(
        .AW      (AW),
        .DIV_MIN (2)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .pk_data      (pk_data),
        .pk_vld       (pk_vld),
        .pk_frm       (pk_frm),
        .cfg_baud_div (cfg_baud_div),
        .cfg_tx_en    (cfg_tx_en),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy),
        .fifo_lvl     (fifo_lvl),
        .ovf_flag     (ovf_flag)
`ifdef PACK_UART_STAT_EN
        ,
        .frm_cnt      (frm_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int busy_cnt = 0;

    // Model state.
    logic [7:0] exp_q[$];
    int         mdl_lvl = 0;
    bit         drop_m  = 1'b0;
    int         start_cyc_q[$];
    int         frame_len_q[$];
    logic [7:0] rx_q[$];
    int         lvl_peak = 0;
    int         wr_cyc   = 0;

    // Monitor state.
    bit         in_frame = 1'b0;
    int         off      = 0;
    int         cur_div  = 2;
    int         prev_div = 4;
    logic [7:0] cur_byte = '0;
    logic [7:0] rx_byte  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    initial forever begin
        @(negedge clk_sys);
        if (tx_busy === 1'b1) busy_cnt++;
    end

    // Frame checker: every frame is start(0), 8 data bits LSB first, stop(1), each bit div cycles,
    // where div = max(cfg_baud_div during the cycle before the start bit, 2).
    initial forever begin
        @(negedge clk_sys);
        if (!rst_n) begin
            in_frame = 1'b0;
            exp_q.delete();
            mdl_lvl  = 0;
            drop_m   = 1'b0;
        end else begin
            check("lvl_bound", 32'(fifo_lvl <= DEPTH), 1);
            if (int'(fifo_lvl) > lvl_peak) lvl_peak = int'(fifo_lvl);
            if (!in_frame && uart_tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("frame_expected", 0, 1);
                    cur_byte = '0;
                end else begin
                    cur_byte = exp_q.pop_front();
                    mdl_lvl--;
                end
                cur_div  = (prev_div < 2) ? 2 : prev_div;
                off      = 0;
                in_frame = 1'b1;
                rx_byte  = '0;
                start_cyc_q.push_back(cyc);
                frame_len_q.push_back(10 * cur_div);
            end
            if (in_frame) begin
                int  bitn;
                logic expbit;
                bitn   = off / cur_div;
                expbit = (bitn == 0) ? 1'b0 : (bitn <= 8) ? cur_byte[bitn-1] : 1'b1;
                check("uart_tx_bit", uart_tx, expbit);
                check("tx_busy_frame", tx_busy, 1);
                if (bitn >= 1 && bitn <= 8 && (off % cur_div) == cur_div / 2) begin
                    rx_byte[bitn-1] = uart_tx;
                end
                off++;
                if (off == 10 * cur_div) begin
                    in_frame = 1'b0;
                    rx_q.push_back(rx_byte);
                end
            end else begin
                check("uart_tx_idle", uart_tx, 1);
                check("tx_busy_idle", tx_busy, 0);
            end
        end
        prev_div = int'(cfg_baud_div);
    end

    // One input cycle; updates the acceptance model with the same byte.
    task automatic drive(input bit vld, input bit frm, input logic [7:0] d);
        @(posedge clk_sys);
        #1;
        pk_vld  = vld;
        pk_frm  = frm;
        pk_data = d;
        if (frm) drop_m = 1'b0;
        if (vld) begin
            wr_cyc = cyc;
            if (mdl_lvl >= DEPTH) drop_m = 1'b1;
            if (!drop_m) begin
                exp_q.push_back(d);
                mdl_lvl++;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_sys);
            if (exp_q.size() == 0 && !in_frame) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_in_time", 32'(done), 1);
        repeat (3) @(posedge clk_sys);
    endtask

    task automatic wait_start(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_sys);
            if (in_frame) begin
                done = 1'b1;
                break;
            end
        end
        check("start_in_time", 32'(done), 1);
    endtask

    task automatic clear_logs();
        start_cyc_q.delete();
        frame_len_q.delete();
        rx_q.delete();
        lvl_peak = 0;
    endtask

    initial begin
        int b0;

        // Reset state.
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_fifo_lvl", fifo_lvl, 0);
        check("rst_ovf", ovf_flag, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        // 1: single byte 0xA5 at div 4.
        clear_logs();
        b0 = busy_cnt;
        drive(1, 1, 8'hA5);
        drive(0, 0, 8'h00);
        wait_idle(200);
        check("t1_latency", start_cyc_q[0] - wr_cyc, 3);
        check("t1_busy_cycles", busy_cnt - b0, 40);
        check("t1_frame_len", frame_len_q[0], 40);
        check("t1_rx", rx_q[0], 8'hA5);

        // 2: burst 0x00..0x09 at div 2.
        cfg_baud_div = 16'd2;
        clear_logs();
        for (int i = 0; i < 10; i++) drive(1, i == 0, 8'(i));
        drive(0, 0, 8'h00);
        wait_idle(600);
        check("t2_peak_9_10", 32'(lvl_peak >= 9 && lvl_peak <= 10), 1);
        check("t2_end_lvl", fifo_lvl, 0);
        check("t2_count", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) check("t2_rx", rx_q[i], 32'(i));
        for (int i = 1; i < 10; i++) check("t2_gap", start_cyc_q[i] - start_cyc_q[i-1], 21);

        // 3: overflow with transmitter held off.
        cfg_baud_div = 16'd4;
        cfg_tx_en    = 1'b0;
        clear_logs();
        for (int i = 0; i < 20; i++) drive(1, i == 0, 8'(8'h10 + i));
        drive(0, 0, 8'h00);
        repeat (2) @(posedge clk_sys);
        #1;
        check("t3_lvl_full", fifo_lvl, 16);
        check("t3_ovf", ovf_flag, 1);
        drive(1, 1, 8'h40);
        drive(1, 0, 8'h41);
        drive(0, 0, 8'h00);
        repeat (2) @(posedge clk_sys);
        #1;
        check("t3_lvl_clamp", fifo_lvl, 16);
`ifdef PACK_UART_STAT_EN
        check("t3_frm_cnt", frm_cnt, 4);
        check("t3_drop_cnt", drop_cnt, 6);
`endif
        cfg_tx_en = 1'b1;
        wait_idle(1500);
        check("t3_count", rx_q.size(), 16);
        check("t3_first", rx_q[0], 8'h10);
        check("t3_last", rx_q[15], 8'h1F);
        check("t3_end_lvl", fifo_lvl, 0);
        check("t3_ovf_sticky", ovf_flag, 1);

        // 4: drop mode still set; pk_frm with pk_vld clears it and keeps the byte.
        cfg_tx_en = 1'b0;
        clear_logs();
        drive(1, 0, 8'h70);
        drive(0, 0, 8'h00);
        @(posedge clk_sys);
        #1;
        check("t4_dropped", fifo_lvl, 0);
        drive(1, 1, 8'h77);
        drive(1, 0, 8'h78);
        drive(0, 0, 8'h00);
        @(posedge clk_sys);
        #1;
        check("t4_written", fifo_lvl, 2);
        cfg_tx_en = 1'b1;
        wait_idle(300);
        check("t4_count", rx_q.size(), 2);
        check("t4_rx0", rx_q[0], 8'h77);
        check("t4_rx1", rx_q[1], 8'h78);

        // 5a: divider 0 clamps to 2.
        cfg_baud_div = 16'd0;
        clear_logs();
        b0 = busy_cnt;
        drive(1, 1, 8'h3C);
        drive(0, 0, 8'h00);
        wait_idle(200);
        check("t5_clamp_busy", busy_cnt - b0, 20);
        check("t5_rx", rx_q[0], 8'h3C);

        // 5b: divider change 4 -> 8 mid-byte takes effect on the next byte.
        cfg_baud_div = 16'd4;
        clear_logs();
        b0 = busy_cnt;
        drive(1, 1, 8'hC3);
        drive(1, 0, 8'h5A);
        drive(0, 0, 8'h00);
        wait_start(50);
        repeat (8) @(posedge clk_sys);
        #1;
        cfg_baud_div = 16'd8;
        wait_idle(400);
        check("t5_busy_total", busy_cnt - b0, 120);
        check("t5_len0", frame_len_q[0], 40);
        check("t5_len1", frame_len_q[1], 80);
        check("t5_gap", start_cyc_q[1] - start_cyc_q[0], 41);
        check("t5_rx0", rx_q[0], 8'hC3);
        check("t5_rx1", rx_q[1], 8'h5A);

        // 6: asynchronous reset during data bit 3 of 0x81 (bit 3 is 0, so the line is low).
        cfg_baud_div = 16'd4;
        clear_logs();
        drive(1, 1, 8'h81);
        drive(1, 0, 8'h82);
        drive(0, 0, 8'h00);
        wait_start(50);
        repeat (16) @(posedge clk_sys);
        #3;
        check("t6_line_low_bit3", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_uart_tx", uart_tx, 1);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_lvl", fifo_lvl, 0);
        check("t6_rst_ovf", ovf_flag, 0);
`ifdef PACK_UART_STAT_EN
        check("t6_rst_frm_cnt", frm_cnt, 0);
        check("t6_rst_drop_cnt", drop_cnt, 0);
`endif
        repeat (2) @(posedge clk_sys);
        #2;
        rst_n = 1'b1;
        clear_logs();
        drive(1, 1, 8'h42);
        drive(0, 0, 8'h00);
        wait_idle(200);
        check("t6_recover_count", rx_q.size(), 1);
        check("t6_recover_rx", rx_q[0], 8'h42);
        check("t6_recover_lvl", fifo_lvl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
